// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one result bit per clock.
// Latency: done pulses in the cycle after edge E+WIDTH (E = accepting edge); one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests seen while busy or done are dropped, never queued.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   // Counter must hold WIDTH-1; keep at least one bit so WIDTH=1 still elaborates.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             br;
   logic             d_bit;
   logic             br_next;
   logic [CW-1:0]    count;

   // Full-subtractor cell on the operand LSBs plus the running borrow; the new
   // bit enters the result register at the MSB so the LSB-first stream lands in place.
   always_comb begin
      d_bit             = a_sr[0] ^ b_sr[0] ^ br;
      br_next           = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_next          = res_sr >> 1;
      res_next[WIDTH-1] = d_bit;
   end

   // Control FSM and datapath; diff/borrow_out only load on the final bit so
   // partial results never reach the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         br         <= 1'b0;
         count      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  br     <= borrow_in;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               br     <= br_next;
               count  <= count + CW'(1);
               if (count == LAST) begin
                  diff       <= res_next;
                  borrow_out <= br_next;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       s8, bi8, busy8, done8, bo8;
   logic [7:0] a8, b8, diff8;

   logic       s1, bi1, busy1, done1, bo1;
   logic [0:0] a1, b1, diff1;

   logic        s16, bi16, busy16, done16, bo16;
   logic [15:0] a16, b16, diff16;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] d;
      logic        bo;
   } exp_t;

   exp_t sb[$];

   // Last result the bench expects dut8 to be holding.
   logic [7:0] last_d8;
   logic       last_b8;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .borrow_in(bi8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .borrow_in(bi1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .borrow_in(bi16),
      .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
      s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
      s16 = 0; a16 = 0; b16 = 0; bi16 = 0;
      last_d8 = 8'd0;
      last_b8 = 1'b0;
      #12;
      total++;
      if ({busy8, done8, bo8, diff8} !== 11'd0) begin
         bad++;
         $display("FAIL reset8: busy=%b done=%b bo=%b diff=%0d want all 0", busy8, done8, bo8, diff8);
      end
      total++;
      if ({busy1, done1, bo1, diff1} !== 4'd0) begin
         bad++;
         $display("FAIL reset1: busy=%b done=%b bo=%b diff=%0d want all 0", busy1, done1, bo1, diff1);
      end
      total++;
      if ({busy16, done16, bo16, diff16} !== 19'd0) begin
         bad++;
         $display("FAIL reset16: busy=%b done=%b bo=%b diff=%0d want all 0", busy16, done16, bo16, diff16);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      tick;
      total++;
      if ({busy8, done8, diff8} !== 10'd0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b done=%b diff=%0d want 0", busy8, done8, diff8);
      end
   endtask

   // One WIDTH=8 operation: checks busy length, done timing, hold of the old
   // result while busy, the result itself and that done is a single pulse.
   task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbi, input string nm);
      logic [8:0] r;
      exp_t       e;
      int         cyc;
      int         busy_cnt;
      bit         hold_ok;
      r = {1'b0, ta} - {1'b0, tb_v} - 9'(tbi);
      sb.push_back('{d: 16'(r[7:0]), bo: r[8]});
      a8 = ta; b8 = tb_v; bi8 = tbi; s8 = 1'b1;
      tick;
      s8  = 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      bi8 = 1'($urandom);
      cyc = 1; busy_cnt = 0; hold_ok = 1;
      while (done8 !== 1'b1 && cyc < 40) begin
         if (busy8 === 1'b1) busy_cnt++;
         if (diff8 !== last_d8 || bo8 !== last_b8) hold_ok = 0;
         tick;
         cyc++;
      end
      total++;
      if (cyc !== 9) begin
         bad++;
         $display("FAIL %s latency: done at cycle %0d want 9", nm, cyc);
      end
      total++;
      if (busy_cnt !== 8) begin
         bad++;
         $display("FAIL %s busy: %0d cycles want 8", nm, busy_cnt);
      end
      total++;
      if (!hold_ok) begin
         bad++;
         $display("FAIL %s hold: outputs changed before done, want diff=%0d bo=%0d", nm, last_d8, last_b8);
      end
      e = sb.pop_front();
      total++;
      if (diff8 !== e.d[7:0] || bo8 !== e.bo) begin
         bad++;
         $display("FAIL %s result: diff=%0d bo=%b want diff=%0d bo=%b", nm, diff8, bo8, e.d[7:0], e.bo);
      end
      last_d8 = e.d[7:0];
      last_b8 = e.bo;
      tick;
      total++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== last_d8) begin
         bad++;
         $display("FAIL %s pulse: done=%b busy=%b diff=%0d want done=0 busy=0 diff=%0d", nm, done8, busy8, diff8, last_d8);
      end
   endtask

   task automatic test_basic;
      do_op8(8'd100, 8'd37,  1'b0, "op_100_37");
      do_op8(8'd5,   8'd10,  1'b0, "op_5_10");
      do_op8(8'd0,   8'd0,   1'b1, "op_0_0_b1");
      do_op8(8'd255, 8'd255, 1'b0, "op_255_255");
      do_op8(8'd200, 8'd1,   1'b1, "op_200_1_b1");
   endtask

   task automatic test_collision;
      exp_t e;
      int   cyc;
      int   ndone;
      sb.push_back('{d: 16'd30, bo: 1'b0});
      a8 = 8'd50; b8 = 8'd20; bi8 = 1'b0; s8 = 1'b1;
      tick;
      s8 = 1'b0;
      cyc = 1;
      tick; tick;
      cyc = 3;
      a8 = 8'd9; b8 = 8'd3; s8 = 1'b1;
      tick;
      s8 = 1'b0;
      cyc = 4;
      while (done8 !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      total++;
      if (cyc !== 9) begin
         bad++;
         $display("FAIL collide latency: done at cycle %0d want 9", cyc);
      end
      e = sb.pop_front();
      total++;
      if (diff8 !== e.d[7:0] || bo8 !== e.bo) begin
         bad++;
         $display("FAIL collide result: diff=%0d bo=%b want diff=%0d bo=%b", diff8, bo8, e.d[7:0], e.bo);
      end
      ndone = 0;
      repeat (15) begin
         tick;
         if (done8 === 1'b1) ndone++;
      end
      total++;
      if (ndone !== 0) begin
         bad++;
         $display("FAIL collide extra_done: %0d extra done pulses want 0", ndone);
      end
      last_d8 = 8'd30;
      last_b8 = 1'b0;
   endtask

   task automatic test_back_to_back;
      int  prev_acc;
      int  nacc;
      int  n;
      logic pb;
      a8 = 8'd20; b8 = 8'd5; bi8 = 1'b0; s8 = 1'b1;
      pb = busy8;
      prev_acc = -1;
      nacc = 0;
      for (int k = 1; k <= 36; k++) begin
         tick;
         if (busy8 === 1'b1 && pb !== 1'b1) begin
            if (prev_acc >= 0) begin
               total++;
               if (k - prev_acc !== 10) begin
                  bad++;
                  $display("FAIL b2b spacing: %0d cycles want 10", k - prev_acc);
               end
            end
            prev_acc = k;
            nacc++;
         end
         if (done8 === 1'b1) begin
            total++;
            if (diff8 !== 8'd15 || bo8 !== 1'b0) begin
               bad++;
               $display("FAIL b2b result: diff=%0d bo=%b want diff=15 bo=0", diff8, bo8);
            end
         end
         pb = busy8;
      end
      total++;
      if (nacc !== 4) begin
         bad++;
         $display("FAIL b2b accepts: %0d want 4", nacc);
      end
      s8 = 1'b0;
      n = 0;
      while ((busy8 === 1'b1 || done8 === 1'b1) && n < 30) begin
         tick;
         n++;
      end
      total++;
      if (n >= 30) begin
         bad++;
         $display("FAIL b2b drain: still busy after %0d cycles want idle", n);
      end
      tick;
      last_d8 = 8'd15;
      last_b8 = 1'b0;
   endtask

   task automatic test_reset_midop;
      sb.push_back('{d: 16'd55, bo: 1'b0});
      a8 = 8'd70; b8 = 8'd15; bi8 = 1'b0; s8 = 1'b1;
      tick;
      s8 = 1'b0;
      tick; tick; tick;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy8, done8, bo8, diff8} !== 11'd0) begin
         bad++;
         $display("FAIL midop_reset: busy=%b done=%b bo=%b diff=%0d want all 0", busy8, done8, bo8, diff8);
      end
      void'(sb.pop_back());
      tick;
      tick;
      rst_n = 1'b1;
      last_d8 = 8'd0;
      last_b8 = 1'b0;
      tick;
      total++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         bad++;
         $display("FAIL midop_discard: done=%b busy=%b want 0 0", done8, busy8);
      end
      do_op8(8'd7, 8'd2, 1'b0, "op_after_reset");
   endtask

   task automatic test_width1;
      logic [1:0] r;
      exp_t       e;
      int         cyc;
      for (int i = 0; i < 8; i++) begin
         a1  = 1'(i >> 2);
         b1  = 1'(i >> 1);
         bi1 = 1'(i);
         r   = {1'b0, a1} - {1'b0, b1} - 2'(bi1);
         sb.push_back('{d: 16'(r[0]), bo: r[1]});
         s1 = 1'b1;
         tick;
         s1 = 1'b0;
         cyc = 1;
         while (done1 !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
         end
         e = sb.pop_front();
         total++;
         if (cyc !== 2 || diff1 !== e.d[0] || bo1 !== e.bo) begin
            bad++;
            $display("FAIL w1 a=%0d b=%0d bin=%0d: cyc=%0d diff=%0d bo=%b want cyc=2 diff=%0d bo=%b",
                     a1, b1, bi1, cyc, diff1, bo1, e.d[0], e.bo);
         end
         tick;
      end
   endtask

   task automatic test_random16;
      logic [16:0] r;
      logic [15:0] ta;
      logic [15:0] tb_v;
      logic        tbi;
      exp_t        e;
      int          cyc;
      for (int i = 0; i < 1000; i++) begin
         ta   = 16'($urandom);
         tb_v = 16'($urandom);
         tbi  = 1'($urandom_range(0, 1));
         if (i == 0) begin ta = 16'd0;     tb_v = 16'hFFFF; tbi = 1'b1; end
         if (i == 1) begin ta = 16'hFFFF;  tb_v = 16'd0;    tbi = 1'b0; end
         r = {1'b0, ta} - {1'b0, tb_v} - 17'(tbi);
         sb.push_back('{d: r[15:0], bo: r[16]});
         a16 = ta; b16 = tb_v; bi16 = tbi; s16 = 1'b1;
         tick;
         s16 = 1'b0;
         cyc = 1;
         while (done16 !== 1'b1 && cyc < 60) begin
            tick;
            cyc++;
         end
         e = sb.pop_front();
         total++;
         if (cyc !== 17 || diff16 !== e.d || bo16 !== e.bo) begin
            bad++;
            $display("FAIL rand16 #%0d a=%0d b=%0d bin=%0d: cyc=%0d diff=%0d bo=%b want cyc=17 diff=%0d bo=%b",
                     i, ta, tb_v, tbi, cyc, diff16, bo16, e.d, e.bo);
         end
         tick;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_collision();
      test_back_to_back();
      test_reset_midop();
      test_width1();
      test_random16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
